// File: rtl/serial_subtractor_fsm.sv
// Bit-serial two's-complement subtractor: one full-adder cell computes a + ~b + 1
// LSB first, one bit per clock, behind a start/done handshake.
module serial_subtractor_fsm #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic             last;

   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-2:0] sh_d;
   logic [WIDTH-1:0] next_d;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             a_msb;
   logic             b_msb;
   logic             cell_s;
   logic             cell_c;

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
      full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last       = (count == LAST);
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Subtraction is addition of the inverted subtrahend with the carry seeded to 1.
   assign {cell_c, cell_s} = full_add(sh_a[0], ~sh_b[0], carry);
   assign next_d           = {cell_s, sh_d};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sh_a       <= '0;
         sh_b       <= '0;
         sh_d       <= '0;
         count      <= '0;
         carry      <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else if (accept) begin
         sh_a  <= a;
         sh_b  <= b;
         sh_d  <= '0;
         count <= '0;
         carry <= 1'b1;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
         sh_a  <= sh_a >> 1;
         sh_b  <= sh_b >> 1;
         sh_d  <= next_d[WIDTH-1:1];
         count <= count + 1'b1;
         carry <= cell_c;
         // Visible results change only on the final bit so diff never shows partial shifts.
         if (last) begin
            diff       <= next_d;
            borrow_out <= ~cell_c;
            overflow   <= (a_msb != b_msb) && (cell_s != a_msb);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Self-checking bench for serial_subtractor_fsm (WIDTH=8): directed corner cases,
// handshake timing, mid-run reset and a random loop against an arithmetic model.
module tb_serial_subtractor_fsm;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         overflow;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] prev_diff = '0;

   serial_subtractor_fsm #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrow_out(borrow_out),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] d, output logic bo, output logic ov);
      int sd;
      sd = int'($signed(x)) - int'($signed(y));
      d  = x - y;
      bo = (int'(x) < int'(y));
      ov = (sd > (2**(W-1)) - 1) || (sd < -(2**(W-1)));
   endfunction

   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input bit inject, input string tag);
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      int           lat;
      lat = -1;
      model(op_a, op_b, ed, eb, eo);
      @(negedge clock);
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      @(posedge clock);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      check({tag, "_busy_on_accept"}, busy, 1);
      check({tag, "_done_on_accept"}, done, 0);
      for (int j = 1; j <= W + 3; j++) begin
         @(posedge clock);
         #1;
         check({tag, "_busy_done_excl"}, busy & done, 0);
         if (inject && j == 3) begin
            start = 1'b1;
            a     = ~op_a;
            b     = op_a;
         end else begin
            start = 1'b0;
         end
         if (j == W / 2) check({tag, "_diff_hold_run"}, diff, prev_diff);
         if (done) begin
            lat = j;
            break;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, lat, W);
      check({tag, "_diff"}, diff, ed);
      check({tag, "_borrow"}, borrow_out, eb);
      check({tag, "_overflow"}, overflow, eo);
      check({tag, "_busy_at_done"}, busy, 0);
      @(posedge clock);
      #1;
      check({tag, "_done_single"}, done, 0);
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_diff_hold_idle"}, diff, ed);
      prev_diff = ed;
   endtask

   initial begin
      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_borrow", borrow_out, 0);
      check("reset_overflow", overflow, 0);
      @(negedge clock);
      reset_n = 1'b1;

      run_op(8'd5, 8'd3, 1'b0, "t1_5m3");
      run_op(8'd3, 8'd5, 1'b0, "t2_3m5");
      run_op(8'd0, 8'd1, 1'b0, "t2_0m1");
      run_op(8'h80, 8'h01, 1'b0, "t3_80m01");
      run_op(8'h7F, 8'hFF, 1'b0, "t3_7Fm FF");
      run_op(8'h21, 8'h10, 1'b1, "t4_ignored_start");

      // Abort an operation after four processed bits.
      @(negedge clock);
      start = 1'b1;
      a     = 8'hC3;
      b     = 8'h5A;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("t5_busy_before_reset", busy, 1);
      reset_n = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_diff", diff, 0);
      check("t5_borrow", borrow_out, 0);
      check("t5_overflow", overflow, 0);
      @(negedge clock);
      reset_n   = 1'b1;
      prev_diff = '0;
      run_op(8'd9, 8'd9, 1'b0, "t5_9m9");

      for (int n = 0; n < 1000; n++) begin
         run_op(W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0), "t6_rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
